// File: rtl/v_noc_pkg.sv
// Shared definitions for the vnet injection path.
//   io_port_t     : router output-port indices (N/S/E/W, first local port L0)
//   crd_cnt_w()   : width of a credit counter that must hold 0..depth
//   fifo_entry_t  : one ingress FIFO slot {flit, head, tail, route}
// The entry struct is sized by NOC_FLIT_W/NOC_PORT_W; users of the struct
// are expected to keep their FLIT_W/PORT_W parameters equal to these.
package v_noc_pkg;

   typedef enum logic [2:0] {
      PORT_N  = 3'd0,
      PORT_S  = 3'd1,
      PORT_E  = 3'd2,
      PORT_W  = 3'd3,
      PORT_L0 = 3'd4
   } io_port_t;

   localparam int NOC_FLIT_W = 128;
   localparam int NOC_PORT_W = 3;

   function automatic int crd_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic [NOC_FLIT_W-1:0] flit;
      logic                  head;
      logic                  tail;
      logic [NOC_PORT_W-1:0] route;
   } fifo_entry_t;

endpackage

// File: rtl/vnet_sync_fifo.sv
// Synchronous FIFO with registered storage and combinational head read.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   wr_en     : write request; ignored while full
//   wr_data   : data written on an accepted write
//   rd_en     : pop request; ignored while empty
//   rd_data   : entry at the head (valid while count != 0)
//   count     : current occupancy, 0..DEPTH
module vnet_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // A write needs room even if a pop happens in the same cycle.
   assign do_wr   = wr_en && (count != CW'(DEPTH));
   assign do_rd   = rd_en && (count != '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vnet_local_injector.sv
// Local injection stage in front of a vnet_router local input port.
// Buffers source flits, computes the XY look-ahead route at enqueue,
// allocates a router VC per packet (round-robin) and tracks per-VC credits.
//   clk, rst                     : clock, synchronous active-high reset
//   node_id_x_i/node_id_y_i      : this node's coordinates
//   req_v_i/req_ready_o          : source handshake (ready = FIFO not full)
//   req_flit_i/head/tail         : flit payload and packet framing
//   req_dst_x_i/y_i/port_i       : destination, sampled on head flits
//   tx_flit_pend_o               : FIFO holds at least one flit
//   tx_flit_v_o/tx_flit_o        : one-cycle flit pulse to the router
//   tx_flit_vc_id_o              : router VC the flit is sent on
//   tx_flit_look_ahead_routing_o : router output port for the flit
//   lcrd_v_i/lcrd_id_i           : credit return from the router
//   err_o                        : sticky protocol/credit error
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no VC owned; a head flit waits for any VC with credit
// ST_PKT  | VC owned by the open packet; flits go out on that VC only
module vnet_local_injector
   import v_noc_pkg::*;
#(
   parameter int FLIT_W     = 128,
   parameter int VC_NUM     = 4,
   parameter int VC_DEPTH   = 4,
   parameter int VC_ID_W    = 3,
   parameter int NODE_X_W   = 2,
   parameter int NODE_Y_W   = 2,
   parameter int PORT_W     = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NODE_X_W-1:0] node_id_x_i,
   input  logic [NODE_Y_W-1:0] node_id_y_i,
   input  logic                req_v_i,
   output logic                req_ready_o,
   input  logic [FLIT_W-1:0]   req_flit_i,
   input  logic                req_head_i,
   input  logic                req_tail_i,
   input  logic [NODE_X_W-1:0] req_dst_x_i,
   input  logic [NODE_Y_W-1:0] req_dst_y_i,
   input  logic [PORT_W-1:0]   req_dst_port_i,
   output logic                tx_flit_pend_o,
   output logic                tx_flit_v_o,
   output logic [FLIT_W-1:0]   tx_flit_o,
   output logic [VC_ID_W-1:0]  tx_flit_vc_id_o,
   output logic [PORT_W-1:0]   tx_flit_look_ahead_routing_o,
   input  logic                lcrd_v_i,
   input  logic [VC_ID_W-1:0]  lcrd_id_i,
   output logic                err_o
);

   typedef enum logic {ST_IDLE, ST_PKT} state_t;

   localparam int CRD_W = crd_cnt_w(VC_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fifo_entry_t        enq_ent;
   fifo_entry_t        head_ent;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_empty;
   logic               enq;

   logic               pkt_open_q;
   logic [PORT_W-1:0]  route_q;
   logic [PORT_W-1:0]  head_route;
   logic               ing_err;

   state_t             state_q;
   logic [VC_ID_W-1:0] own_vc_q;
   logic [VC_ID_W-1:0] rr_ptr_q;
   logic [VC_ID_W-1:0] rr_next;

   logic [CRD_W-1:0]   credit_q [VC_NUM];
   logic [VC_NUM-1:0]  has_crd;
   logic [VC_NUM-1:0]  crd_inc;
   logic [VC_NUM-1:0]  crd_dec;
   logic [VC_NUM-1:0]  crd_ovf;
   logic               own_ok;
   logic               alloc_ok;
   logic [VC_ID_W-1:0] alloc_vc;
   logic               lcrd_bad;

   logic               send;
   logic               drop;
   logic [VC_ID_W-1:0] send_vc;

   assign req_ready_o    = (fifo_count != CNT_W'(FIFO_DEPTH));
   assign fifo_empty     = (fifo_count == '0);
   assign tx_flit_pend_o = !fifo_empty;
   assign enq            = req_v_i && req_ready_o;

   always_comb begin
      if (req_dst_x_i > node_id_x_i) begin
         head_route = PORT_W'(PORT_E);
      end else if (req_dst_x_i < node_id_x_i) begin
         head_route = PORT_W'(PORT_W);
      end else if (req_dst_y_i > node_id_y_i) begin
         head_route = PORT_W'(PORT_N);
      end else if (req_dst_y_i < node_id_y_i) begin
         head_route = PORT_W'(PORT_S);
      end else begin
         head_route = PORT_W'(PORT_L0) + req_dst_port_i;
      end
   end

   always_comb begin
      enq_ent.flit  = req_flit_i;
      enq_ent.head  = req_head_i;
      enq_ent.tail  = req_tail_i;
      enq_ent.route = req_head_i ? head_route : route_q;
   end

   // Framing is checked at ingress, independent of what egress is doing.
   assign ing_err = enq && (req_head_i ? pkt_open_q : !pkt_open_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_open_q <= 1'b0;
         route_q    <= '0;
      end else if (enq) begin
         if (req_head_i) begin
            route_q    <= head_route;
            pkt_open_q <= !req_tail_i;
         end else if (req_tail_i) begin
            pkt_open_q <= 1'b0;
         end
      end
   end

   vnet_sync_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (enq),
      .wr_data (enq_ent),
      .rd_en   (send || drop),
      .rd_data (head_ent),
      .count   (fifo_count)
   );

   always_comb begin
      has_crd = '0;
      own_ok  = 1'b0;
      for (int v = 0; v < VC_NUM; v++) begin
         has_crd[v] = (credit_q[v] != '0);
         if (own_vc_q == VC_ID_W'(v) && credit_q[v] != '0) begin
            own_ok = 1'b1;
         end
      end
   end

   // Round-robin search starting at rr_ptr_q, the VC after the last grant.
   always_comb begin
      alloc_ok = 1'b0;
      alloc_vc = '0;
      for (int i = 0; i < VC_NUM; i++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (!alloc_ok && has_crd[v] && ((int'(rr_ptr_q) + i) % VC_NUM) == v) begin
               alloc_ok = 1'b1;
               alloc_vc = VC_ID_W'(v);
            end
         end
      end
   end

   assign rr_next = (alloc_vc == VC_ID_W'(VC_NUM - 1)) ? '0 : alloc_vc + VC_ID_W'(1);

   // A non-head flit reaching the head in IDLE belongs to no packet; it is
   // discarded so it cannot block the queue (err_o already flagged it).
   always_comb begin
      send    = 1'b0;
      drop    = 1'b0;
      send_vc = own_vc_q;
      if (!fifo_empty) begin
         if (state_q == ST_IDLE) begin
            if (!head_ent.head) begin
               drop = 1'b1;
            end else if (alloc_ok) begin
               send    = 1'b1;
               send_vc = alloc_vc;
            end
         end else if (own_ok) begin
            send = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q                      <= ST_IDLE;
         own_vc_q                     <= '0;
         rr_ptr_q                     <= '0;
         tx_flit_v_o                  <= 1'b0;
         tx_flit_o                    <= '0;
         tx_flit_vc_id_o              <= '0;
         tx_flit_look_ahead_routing_o <= '0;
      end else begin
         tx_flit_v_o <= send;
         if (send) begin
            tx_flit_o                    <= head_ent.flit;
            tx_flit_vc_id_o              <= send_vc;
            tx_flit_look_ahead_routing_o <= head_ent.route;
            case (state_q)
               ST_IDLE: begin
                  own_vc_q <= alloc_vc;
                  rr_ptr_q <= rr_next;
                  state_q  <= head_ent.tail ? ST_IDLE : ST_PKT;
               end
               ST_PKT: begin
                  if (head_ent.tail) begin
                     state_q <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign lcrd_bad = lcrd_v_i && (32'(lcrd_id_i) >= VC_NUM);

   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         crd_inc[v] = lcrd_v_i && (lcrd_id_i == VC_ID_W'(v));
         crd_dec[v] = send && (send_vc == VC_ID_W'(v));
         crd_ovf[v] = crd_inc[v] && !crd_dec[v] && (credit_q[v] == CRD_W'(VC_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VC_NUM; v++) begin
            credit_q[v] <= CRD_W'(VC_DEPTH);
         end
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (crd_inc[v] && !crd_dec[v] && !crd_ovf[v]) begin
               credit_q[v] <= credit_q[v] + CRD_W'(1);
            end else if (crd_dec[v] && !crd_inc[v]) begin
               credit_q[v] <= credit_q[v] - CRD_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_o <= 1'b0;
      end else if (lcrd_bad || ing_err || (|crd_ovf)) begin
         err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vnet_local_injector.sv
module tb_vnet_local_injector;

   logic         clk;
   logic         rst;
   logic [1:0]   node_id_x;
   logic [1:0]   node_id_y;
   logic         req_v;
   logic         req_ready;
   logic [127:0] req_flit;
   logic         req_head;
   logic         req_tail;
   logic [1:0]   req_dst_x;
   logic [1:0]   req_dst_y;
   logic [2:0]   req_dst_port;
   logic         tx_pend;
   logic         tx_v;
   logic [127:0] tx_flit;
   logic [2:0]   tx_vc;
   logic [2:0]   tx_route;
   logic         lcrd_v;
   logic [2:0]   lcrd_id;
   logic         err;

   typedef struct {
      logic [127:0] flit;
      logic [2:0]   vc;
      logic [2:0]   route;
   } exp_t;

   exp_t exp_q[$];
   int   errors   = 0;
   int   checks   = 0;
   int   sent_cnt = 0;

   vnet_local_injector dut (
      .clk                          (clk),
      .rst                          (rst),
      .node_id_x_i                  (node_id_x),
      .node_id_y_i                  (node_id_y),
      .req_v_i                      (req_v),
      .req_ready_o                  (req_ready),
      .req_flit_i                   (req_flit),
      .req_head_i                   (req_head),
      .req_tail_i                   (req_tail),
      .req_dst_x_i                  (req_dst_x),
      .req_dst_y_i                  (req_dst_y),
      .req_dst_port_i               (req_dst_port),
      .tx_flit_pend_o               (tx_pend),
      .tx_flit_v_o                  (tx_v),
      .tx_flit_o                    (tx_flit),
      .tx_flit_vc_id_o              (tx_vc),
      .tx_flit_look_ahead_routing_o (tx_route),
      .lcrd_v_i                     (lcrd_v),
      .lcrd_id_i                    (lcrd_id),
      .err_o                        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every flit pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (tx_v === 1'b1) begin
         sent_cnt++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_flit: observed flit=%0h vc=%0d with no expectation queued", tx_flit, tx_vc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_flit", tx_flit, e.flit);
            chk("out_vc", 128'(tx_vc), 128'(e.vc));
            chk("out_route", 128'(tx_route), 128'(e.route));
         end
      end
   end

   task automatic idle_inputs();
      req_v        = 1'b0;
      req_flit     = '0;
      req_head     = 1'b0;
      req_tail     = 1'b0;
      req_dst_x    = '0;
      req_dst_y    = '0;
      req_dst_port = '0;
      lcrd_v       = 1'b0;
      lcrd_id      = '0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      sent_cnt = 0;
   endtask

   task automatic push(input logic [127:0] f, input logic h, input logic t,
                       input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] port,
                       input logic track, input logic [2:0] evc, input logic [2:0] eroute);
      exp_t e;
      req_v        = 1'b1;
      req_flit     = f;
      req_head     = h;
      req_tail     = t;
      req_dst_x    = dx;
      req_dst_y    = dy;
      req_dst_port = port;
      if (track) begin
         e.flit  = f;
         e.vc    = evc;
         e.route = eroute;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_v    = 1'b0;
      req_head = 1'b0;
      req_tail = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(tag, 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      node_id_x = 2'd1;
      node_id_y = 2'd1;
      idle_inputs();
      do_reset();

      // Reset values
      @(negedge clk);
      chk("rst_tx_v", 128'(tx_v), 128'(0));
      chk("rst_pend", 128'(tx_pend), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_ready", 128'(req_ready), 128'(1));
      chk("rst_flit", tx_flit, 128'(0));
      chk("rst_vc", 128'(tx_vc), 128'(0));
      chk("rst_route", 128'(tx_route), 128'(0));
      chk("rst_crd0", 128'(dut.credit_q[0]), 128'(4));
      chk("rst_crd3", 128'(dut.credit_q[3]), 128'(4));

      // Single-flit packet to own node, local port 1 -> route 5, VC 0, c+2
      push(128'hA1, 1'b1, 1'b1, 2'd1, 2'd1, 3'd1, 1'b1, 3'd0, 3'd5);
      @(negedge clk);
      chk("lat_c1", 128'(tx_v), 128'(0));
      @(negedge clk);
      chk("lat_c2", 128'(tx_v), 128'(1));
      chk("t1_crd0", 128'(dut.credit_q[0]), 128'(3));

      // 3-flit packet east, then a 2-flit packet north on the next VC
      node_id_x = 2'd0;
      node_id_y = 2'd0;
      do_reset();
      push(128'hB0, 1'b1, 1'b0, 2'd1, 2'd0, 3'd0, 1'b1, 3'd0, 3'd2);
      push(128'hB1, 1'b0, 1'b0, 2'd0, 2'd1, 3'd0, 1'b1, 3'd0, 3'd2);
      push(128'hB2, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0, 1'b1, 3'd0, 3'd2);
      push(128'hC0, 1'b1, 1'b0, 2'd0, 2'd1, 3'd0, 1'b1, 3'd1, 3'd0);
      push(128'hC1, 1'b0, 1'b1, 2'd3, 2'd3, 3'd0, 1'b1, 3'd1, 3'd0);
      wait_drain("t2_drain", 20);
      chk("t2_err", 128'(err), 128'(0));

      // Credit exhaustion: 18 single-flit packets west, only 16 credits
      node_id_x = 2'd1;
      node_id_y = 2'd1;
      do_reset();
      for (int i = 0; i < 18; i++) begin
         push(128'h300 + 128'(i), 1'b1, 1'b1, 2'd0, 2'd1, 3'd0, (i < 17),
              (i < 16) ? 3'(i % 4) : 3'd2, 3'd3);
      end
      cycles(8);
      chk("t3_sent16", 128'(sent_cnt), 128'(16));
      chk("t3_pend", 128'(tx_pend), 128'(1));
      chk("t3_left", 128'(exp_q.size()), 128'(1));
      chk("t3_crd2_empty", 128'(dut.credit_q[2]), 128'(0));
      lcrd_v  = 1'b1;
      lcrd_id = 3'd2;
      @(posedge clk);
      #1;
      lcrd_v = 1'b0;
      cycles(4);
      chk("t3_sent17", 128'(sent_cnt), 128'(17));
      chk("t3_released", 128'(exp_q.size()), 128'(0));
      chk("t3_pend_after", 128'(tx_pend), 128'(1));
      chk("t3_err", 128'(err), 128'(0));

      // Fill the FIFO (one flit already stuck), ending mid-packet
      for (int i = 0; i < 6; i++) begin
         push(128'h400 + 128'(i), 1'b1, 1'b1, 2'd0, 2'd1, 3'd0, 1'b0, 3'd0, 3'd0);
      end
      chk("fill_ready_7", 128'(req_ready), 128'(1));
      push(128'h4FF, 1'b1, 1'b0, 2'd0, 2'd1, 3'd0, 1'b0, 3'd0, 3'd0);
      chk("fill_ready_0", 128'(req_ready), 128'(0));
      chk("fill_pend", 128'(tx_pend), 128'(1));
      chk("fill_err", 128'(err), 128'(0));

      // Reset mid-packet
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_tx_v", 128'(tx_v), 128'(0));
      chk("mid_rst_pend", 128'(tx_pend), 128'(0));
      chk("mid_rst_ready", 128'(req_ready), 128'(1));
      chk("mid_rst_flit", tx_flit, 128'(0));
      chk("mid_rst_vc", 128'(tx_vc), 128'(0));
      chk("mid_rst_route", 128'(tx_route), 128'(0));
      chk("mid_rst_crd0", 128'(dut.credit_q[0]), 128'(4));
      chk("mid_rst_crd1", 128'(dut.credit_q[1]), 128'(4));
      chk("mid_rst_crd2", 128'(dut.credit_q[2]), 128'(4));
      chk("mid_rst_crd3", 128'(dut.credit_q[3]), 128'(4));
      rst = 1'b0;
      exp_q.delete();
      sent_cnt = 0;
      push(128'h500, 1'b1, 1'b1, 2'd1, 2'd1, 3'd0, 1'b1, 3'd0, 3'd4);
      wait_drain("post_rst_drain", 10);
      chk("post_rst_err", 128'(err), 128'(0));

      // Send and credit return on the same VC in the same cycle
      do_reset();
      push(128'h600, 1'b1, 1'b1, 2'd1, 2'd0, 3'd0, 1'b1, 3'd0, 3'd1);
      lcrd_v  = 1'b1;
      lcrd_id = 3'd0;
      @(posedge clk);
      #1;
      lcrd_v = 1'b0;
      chk("same_cyc_sent", 128'(tx_v), 128'(1));
      chk("same_cyc_crd0", 128'(dut.credit_q[0]), 128'(4));
      chk("same_cyc_err", 128'(err), 128'(0));

      // Extra credit on a full VC
      lcrd_v  = 1'b1;
      lcrd_id = 3'd1;
      chk("ovf_pre", 128'(err), 128'(0));
      @(posedge clk);
      #1;
      lcrd_v = 1'b0;
      chk("ovf_set", 128'(err), 128'(1));
      chk("ovf_sat", 128'(dut.credit_q[1]), 128'(4));
      cycles(3);
      chk("err_sticky", 128'(err), 128'(1));

      // Out-of-range credit id
      do_reset();
      chk("err_cleared", 128'(err), 128'(0));
      lcrd_v  = 1'b1;
      lcrd_id = 3'd7;
      @(posedge clk);
      #1;
      lcrd_v = 1'b0;
      chk("bad_id_err", 128'(err), 128'(1));
      chk("bad_id_crd3", 128'(dut.credit_q[3]), 128'(4));

      // Tail flit with no packet open
      do_reset();
      push(128'h700, 1'b0, 1'b1, 2'd1, 2'd1, 3'd0, 1'b0, 3'd0, 3'd0);
      chk("stray_err", 128'(err), 128'(1));
      cycles(4);

      // Head flit while a packet is open; both go out on the owned VC
      do_reset();
      push(128'h800, 1'b1, 1'b0, 2'd2, 2'd1, 3'd0, 1'b1, 3'd0, 3'd2);
      chk("dup_head_pre", 128'(err), 128'(0));
      push(128'h801, 1'b1, 1'b1, 2'd2, 2'd1, 3'd0, 1'b1, 3'd0, 3'd2);
      chk("dup_head_err", 128'(err), 128'(1));
      wait_drain("dup_head_drain", 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
